// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared types and constants for the LED instruction sequencer.
//   state_t      sequencer state (FETCH / HOLD)
//   PAT_* CNT_*  bit fields of a 16-bit instruction word
//   END_WORD     instruction that restarts the program at address 0
//   HOLD_CNT_W   width of the tick counter (must hold 256)
package led_seq_pkg;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int PAT_MSB = 15;
    localparam int PAT_LSB = 8;
    localparam int CNT_MSB = 7;
    localparam int CNT_LSB = 0;

    localparam logic [15:0] END_WORD   = 16'h0000;
    localparam int          HOLD_CNT_W = 9;

endpackage

// File: rtl/led_seq_tick.sv
// led_seq_tick: hold-tick prescaler.
//   clk   system clock, rising edge
//   rst   synchronous reset, active-high
//   clr   restart the count from zero
//   en    count enable; counting freezes while low
//   tick  one-cycle pulse on every TICK_DIV-th enabled cycle
module led_seq_tick #(
    parameter int TICK_DIV = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int              CW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0]   LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = en && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/led_seq_core.sv
// led_seq_core: instruction sequencer in front of a combinational program ROM.
// Each word is {pattern[7:0], count[7:0]}; the pattern is shown on leds for
// count hold ticks (count 0 = 256), then the next word is fetched. The word
// 16'h0000 restarts the program at address 0 and pulses wrap.
//   clk      system clock, rising edge
//   rst      synchronous reset, active-high
//   en       run enable; low freezes sequencing
//   step     single-step request (only with LED_SEQ_STEP_EN defined)
//   addr_rd  ROM read address (= pc)
//   data_rd  ROM read data, combinational from addr_rd
//   leds     registered LED pattern
//   busy     high while holding a pattern
//   wrap     one-cycle pulse when the end word restarts the program
// Build option: LED_SEQ_STEP_EN adds the step port; with en low each step
// pulse either executes the pending fetch or terminates the current hold.
module led_seq_core
    import led_seq_pkg::*;
#(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 16,
    parameter int TICK_DIV = 50000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
`ifdef LED_SEQ_STEP_EN
    input  logic              step,
`endif
    output logic [ADDR_W-1:0] addr_rd,
    input  logic [DATA_W-1:0] data_rd,
    output logic [7:0]        leds,
    output logic              busy,
    output logic              wrap
);

    state_t                  state;
    logic [ADDR_W-1:0]       pc;
    logic [HOLD_CNT_W-1:0]   remaining;
    logic                    wrap_q;

    logic [7:0]              pattern;
    logic [7:0]              count;
    logic                    is_end;
    logic                    fetch_go;
    logic                    hold_kill;
    logic                    tick;
    logic                    hold_done;

    assign pattern = data_rd[PAT_MSB:PAT_LSB];
    assign count   = data_rd[CNT_MSB:CNT_LSB];
    assign is_end  = (data_rd == END_WORD);

`ifdef LED_SEQ_STEP_EN
    // step only acts while en is low; with en high it is redundant.
    assign fetch_go  = (state == FETCH) && (en || step);
    assign hold_kill = (state == HOLD) && !en && step;
`else
    assign fetch_go  = (state == FETCH) && en;
    assign hold_kill = 1'b0;
`endif

    // Prescaler is cleared on every executed fetch so a hold cut short by
    // a step pulse does not leak a partial tick into the next instruction.
    led_seq_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (fetch_go),
        .en   ((state == HOLD) && en),
        .tick (tick)
    );

    assign hold_done = tick && (remaining == HOLD_CNT_W'(1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= '0;
            remaining <= '0;
            leds      <= '0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            case (state)
                FETCH: begin
                    if (fetch_go) begin
                        if (is_end) begin
                            pc     <= '0;
                            wrap_q <= en;
                        end else begin
                            leds      <= pattern;
                            remaining <= (count == 8'd0) ? HOLD_CNT_W'(256)
                                                         : HOLD_CNT_W'(count);
                            state     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        remaining <= remaining - 1'b1;
                    end
                    if (hold_done || hold_kill) begin
                        pc    <= pc + 1'b1;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign addr_rd = pc;
    assign busy    = (state == HOLD);
    assign wrap    = wrap_q && en;

endmodule

// File: tb/tb_led_seq_core.sv
// Scoreboard bench for led_seq_core with TICK_DIV=2. The reference model
// tracks the position inside the current instruction and derives outputs
// from the instruction length (count*TICK_DIV+1 cycles, count 0 = 256).
module tb_led_seq_core;

    localparam int TD   = 2;
    localparam int NCYC = 6000;
    localparam int RAND_START = 2600;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        step;
    logic [7:0]  addr_rd;
    logic [15:0] data_rd;
    logic [7:0]  leds;
    logic        busy;
    logic        wrap;

    logic [15:0] rom [256];
    assign data_rd = rom[addr_rd];

    always #5 clk = ~clk;

    led_seq_core #(
        .ADDR_W   (8),
        .DATA_W   (16),
        .TICK_DIV (TD)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
`ifdef LED_SEQ_STEP_EN
        .step    (step),
`endif
        .addr_rd (addr_rd),
        .data_rd (data_rd),
        .leds    (leds),
        .busy    (busy),
        .wrap    (wrap)
    );

    typedef struct {
        logic [7:0] addr;
        logic [7:0] leds;
        logic       busy;
        logic       wrap;
    } exp_t;

    exp_t q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Reference model state
    int         m_pc    = 0;
    int         m_k     = 0;   // cycles spent in current instruction (0 = fetch cycle)
    logic [7:0] m_last  = 8'h00;
    bit         m_wrapf = 1'b0;

    function automatic int instr_len(input logic [15:0] w);
        int c;
        c = int'(w[7:0]);
        if (c == 0) c = 256;
        return c * TD + 1;
    endfunction

    task automatic model_cycle(input bit r, input bit e, input bit s);
        exp_t       x;
        logic [15:0] w;
        bit          nw;
        w      = rom[m_pc];
        x.addr = 8'(m_pc);
        x.busy = (m_k > 0);
        x.leds = (m_k > 0) ? w[15:8] : m_last;
        x.wrap = m_wrapf && e;
        q.push_back(x);
        nw = 1'b0;
        if (r) begin
            m_pc = 0; m_k = 0; m_last = 8'h00;
        end else if ((e || s) && m_k == 0) begin
            if (w == 16'h0000) begin
                m_pc = 0;
                nw   = e;
            end else begin
                m_k = 1;
            end
        end else if (e && m_k > 0) begin
            m_k++;
            if (m_k == instr_len(w)) begin
                m_last = w[15:8];
                m_pc   = (m_pc + 1) % 256;
                m_k    = 0;
            end
        end else if (!e && s && m_k > 0) begin
            m_last = w[15:8];
            m_pc   = (m_pc + 1) % 256;
            m_k    = 0;
        end
        m_wrapf = nw;
    endtask

    // Monitor: one output sample per cycle, away from the active edge.
    initial begin
        exp_t x;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                x = q.pop_front();
                vectors++;
                if (addr_rd !== x.addr || leds !== x.leds ||
                    busy !== x.busy || wrap !== x.wrap) begin
                    miscompares++;
                    $display("FAIL outputs @%0t: got addr=%h leds=%h busy=%b wrap=%b, required addr=%h leds=%h busy=%b wrap=%b",
                             $time, addr_rd, leds, busy, wrap, x.addr, x.leds, x.busy, x.wrap);
                end
            end
        end
    end

    initial begin
        bit r, e, s;
        bit froze, did_rst;
        int freeze_left;
        froze = 0; did_rst = 0; freeze_left = 0;
        rst = 1'b1; en = 1'b0; step = 1'b0;

        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
        rom[8'h00] = 16'hA010;
        rom[8'h01] = 16'h5014;
        rom[8'h02] = 16'h0A00;
        rom[8'h03] = 16'h3303;
        rom[8'h04] = 16'hFFFF;
        rom[8'h05] = 16'h1201;
        rom[8'h06] = 16'h2402;
        rom[8'h07] = 16'h4803;
        rom[8'h08] = 16'h8104;
        rom[8'h09] = 16'hC305;
        rom[8'h0A] = 16'hE706;
        rom[8'h0B] = 16'h0F01;
        rom[8'h0C] = 16'hF002;
        rom[8'h0D] = 16'h5005;
        rom[8'h0E] = 16'h0000;

        repeat (3) @(posedge clk);

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            #1;
            r = 0; e = 1; s = 0;
            if (freeze_left > 0) begin
                e = 0;
                freeze_left--;
            end else if (!froze && m_pc == 1 && m_k == 5) begin
                froze = 1; e = 0; freeze_left = 9;
            end else if (froze && !did_rst && m_pc == 3 && m_k == 2) begin
                did_rst = 1; r = 1;
            end else if (cyc >= RAND_START) begin
                e = ($urandom_range(0, 7) != 0);
                r = ($urandom_range(0, 1499) == 0);
`ifdef LED_SEQ_STEP_EN
                s = ($urandom_range(0, 1) == 1);
`endif
            end
            rst = r; en = e; step = s;
            model_cycle(r, e, s);
            @(posedge clk);
        end

`ifdef LED_SEQ_STEP_EN
        // All-0101 program without an end word: stepping must roll pc over.
        #1;
        rst = 1'b1; en = 1'b0; step = 1'b0;
        model_cycle(1, 0, 0);
        for (int i = 0; i < 256; i++) rom[i] = 16'h0101;
        @(posedge clk);
        for (int cyc = 0; cyc < 1200; cyc++) begin
            #1;
            e = ($urandom_range(0, 15) == 0);
            s = ($urandom_range(0, 3) != 0);
            rst = 1'b0; en = e; step = s;
            model_cycle(0, e, s);
            @(posedge clk);
        end
`endif

        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expected samples left, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
